// File: rtl/fwrisc_pkg.sv
// Shared types for the regfile debug-port arbiter.
package fwrisc_pkg;

    localparam int DBG_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RD_RESP = 2'd2,
        WR_RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/fwrisc_regfile_dbg_arb_if.sv
// Debug/host access port into the regfile arbiter.
interface fwrisc_regfile_dbg_arb_if;
    import fwrisc_pkg::*;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [DBG_ADDR_W-1:0] dbg_addr;
    logic [31:0]           dbg_wdata;
    logic                  dbg_ack;
    logic [31:0]           dbg_rdata;

    modport master (
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata
    );

    modport slave (
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/fwrisc_sat_counter.sv
// Saturating up-counter; clear together with inc loads 1.
module fwrisc_sat_counter #(
    parameter int W   = 5,
    parameter int MAX = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic at_max
);

    logic [W-1:0] cnt;

    assign at_max = (cnt == W'(MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fwrisc_regfile_dbg_arb.sv
// Shares the regfile write port and RB read port between the core (priority)
// and a debug access port, stalling the core if debug starves.
module fwrisc_regfile_dbg_arb
    import fwrisc_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  core_busy,
    input  logic [DBG_ADDR_W-1:0] core_rb_raddr,
    input  logic [DBG_ADDR_W-1:0] core_rd_waddr,
    input  logic [31:0]           core_rd_wdata,
    input  logic                  core_rd_wen,
    output logic                  core_stall,

    fwrisc_regfile_dbg_arb_if.slave dbg,

    output logic [DBG_ADDR_W-1:0] rf_rb_raddr,
    output logic [DBG_ADDR_W-1:0] rf_rd_waddr,
    output logic [31:0]           rf_rd_wdata,
    output logic                  rf_rd_wen,
    input  logic [31:0]           rf_rb_rdata
);

    arb_state_e  state, state_nxt;
    logic        req_live, grant;
    logic        cnt_clear, cnt_inc, at_max;
    logic        ack_q;
    logic [31:0] rdata_q;

    // During the ack cycle the requester is still holding the old request;
    // ignoring it there keeps a completed access from being re-issued.
    assign req_live = dbg.dbg_req && !ack_q;
    assign grant    = (state == IDLE || state == WAIT) && req_live && !core_busy;

    always_comb begin
        state_nxt = state;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (grant) begin
                    state_nxt = dbg.dbg_we ? WR_RESP : RD_RESP;
                end else if (req_live) begin
                    state_nxt = WAIT;
                    cnt_inc   = 1'b1;
                end
            end
            WAIT: begin
                if (!dbg.dbg_req) begin
                    state_nxt = IDLE;
                    cnt_clear = 1'b1;
                end else if (grant) begin
                    state_nxt = dbg.dbg_we ? WR_RESP : RD_RESP;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            core_stall <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state      <= state_nxt;
            core_stall <= (state == WAIT) && (state_nxt == WAIT) && at_max;
            ack_q      <= (grant && dbg.dbg_we) || (state == RD_RESP);
            if (state == RD_RESP) begin
                rdata_q <= rf_rb_rdata;
            end
        end
    end

    fwrisc_sat_counter #(
        .W   (WAIT_W),
        .MAX (MAX_WAIT)
    ) u_wait_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .at_max (at_max)
    );

    // grant implies !core_busy, so the two sources never share a cycle
    always_comb begin
        rf_rb_raddr = core_rb_raddr;
        rf_rd_waddr = core_rd_waddr;
        rf_rd_wdata = core_rd_wdata;
        rf_rd_wen   = core_rd_wen;
        if (grant) begin
            rf_rb_raddr = dbg.dbg_addr;
            rf_rd_wen   = dbg.dbg_we;
            if (dbg.dbg_we) begin
                rf_rd_waddr = dbg.dbg_addr;
                rf_rd_wdata = dbg.dbg_wdata;
            end
        end
    end

    assign dbg.dbg_ack   = ack_q;
    assign dbg.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_fwrisc_regfile_dbg_arb.sv
// Randomized and directed checks of the regfile debug arbiter against a shadow regfile.
module tb_fwrisc_regfile_dbg_arb;

    localparam int MAX_WAIT = 4;
    localparam logic [5:0] MSCRATCH = 6'h28;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        core_busy = 1'b0;
    logic [5:0]  core_rb_raddr = '0;
    logic [5:0]  core_rd_waddr = '0;
    logic [31:0] core_rd_wdata = '0;
    logic        core_rd_wen = 1'b0;
    logic        core_stall;
    logic [5:0]  rf_rb_raddr, rf_rd_waddr;
    logic [31:0] rf_rd_wdata;
    logic        rf_rd_wen;
    logic [31:0] rf_rb_rdata = '0;

    fwrisc_regfile_dbg_arb_if dbg_bus();

    fwrisc_regfile_dbg_arb #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5)) dut (
        .clock(clock), .reset(reset),
        .core_busy(core_busy), .core_rb_raddr(core_rb_raddr),
        .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata),
        .core_rd_wen(core_rd_wen), .core_stall(core_stall),
        .dbg(dbg_bus),
        .rf_rb_raddr(rf_rb_raddr), .rf_rd_waddr(rf_rd_waddr),
        .rf_rd_wdata(rf_rd_wdata), .rf_rd_wen(rf_rd_wen),
        .rf_rb_rdata(rf_rb_rdata)
    );

    always #5 clock = ~clock;

    // Regfile: registered RB read, x0 hard-wired to zero.
    logic [31:0] regs [64];
    logic [31:0] shadow [64];
    bit          rf_init = 1'b1;

    function automatic logic [31:0] init_val(int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h111;
    endfunction

    always @(posedge clock) begin
        if (rf_init) begin
            for (int i = 0; i < 64; i++) regs[i] <= init_val(i);
        end else if (rf_rd_wen && rf_rd_waddr != 6'd0) begin
            regs[rf_rd_waddr] <= rf_rd_wdata;
        end
        rf_rb_rdata <= (rf_rb_raddr == 6'd0) ? 32'h0 : regs[rf_rb_raddr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Snapshot of the regfile-side outputs in the first cycle of a debug request.
    logic        t0_wen;
    logic [5:0]  t0_waddr, t0_raddr;
    logic [31:0] t0_wdata;

    // Call at posedge+1; returns at posedge+1 with the request dropped.
    task automatic dbg_op(input logic we, input logic [5:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic st);
        dbg_bus.dbg_req   = 1'b1;
        dbg_bus.dbg_we    = we;
        dbg_bus.dbg_addr  = a;
        dbg_bus.dbg_wdata = wd;
        lat = -1;
        rd  = '0;
        st  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (c == 0) begin
                t0_wen = rf_rd_wen; t0_waddr = rf_rd_waddr;
                t0_wdata = rf_rd_wdata; t0_raddr = rf_rb_raddr;
            end
            st = st | core_stall;
            if (dbg_bus.dbg_ack) begin
                rd  = dbg_bus.dbg_rdata;
                lat = c;
                break;
            end
        end
        chk("ack_seen", 32'(lat >= 0), 32'd1);
        @(posedge clock); #1;
        dbg_bus.dbg_req = 1'b0;
    endtask

    task automatic core_wr(input logic [5:0] a, input logic [31:0] d);
        core_busy = 1'b1; core_rd_wen = 1'b1; core_rd_waddr = a; core_rd_wdata = d;
        if (a != 6'd0) shadow[a] = d;
        @(posedge clock); #1;
        core_busy = 1'b0; core_rd_wen = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    logic        st;
    bit          rnd_done;

    initial begin
        dbg_bus.dbg_req = 1'b0; dbg_bus.dbg_we = 1'b0;
        dbg_bus.dbg_addr = '0; dbg_bus.dbg_wdata = '0;
        for (int i = 0; i < 64; i++) shadow[i] = init_val(i);
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_stall", 32'(core_stall), 32'd0);
        chk("rst_ack", 32'(dbg_bus.dbg_ack), 32'd0);
        chk("rst_rdata", dbg_bus.dbg_rdata, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0; rf_init = 1'b0;

        // Read with core idle: issue in the request cycle, ack two later.
        core_wr(6'd5, 32'h1234);
        dbg_op(1'b0, 6'd5, 32'h0, rd, lat, st);
        chk("t1_raddr", 32'(t0_raddr), 32'd5);
        chk("t1_lat", 32'(lat), 32'd2);
        chk("t1_rdata", rd, 32'h1234);
        chk("t1_stall", 32'(st), 32'd0);

        // Write with core idle.
        dbg_op(1'b1, 6'd7, 32'hDEADBEEF, rd, lat, st);
        shadow[7] = 32'hDEADBEEF;
        chk("t2_wen", 32'(t0_wen), 32'd1);
        chk("t2_waddr", 32'(t0_waddr), 32'd7);
        chk("t2_wdata", t0_wdata, 32'hDEADBEEF);
        chk("t2_lat", 32'(lat), 32'd1);
        dbg_op(1'b0, 6'd7, 32'h0, rd, lat, st);
        chk("t2_readback", rd, 32'hDEADBEEF);

        // Starvation: stall shows up once debug has sat MAX_WAIT cycles in WAIT.
        core_busy = 1'b1;
        dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b0; dbg_bus.dbg_addr = 6'd40;
        for (int c = 0; c < 9; c++) begin
            @(negedge clock);
            chk($sformatf("t3_stall_c%0d", c), 32'(core_stall), 32'(c >= MAX_WAIT + 1));
        end
        @(posedge clock); #1;
        core_busy = 1'b0;
        @(negedge clock);
        chk("t3_grant_raddr", 32'(rf_rb_raddr), 32'd40);
        @(negedge clock);
        chk("t3_stall_clr", 32'(core_stall), 32'd0);
        chk("t3_ack_early", 32'(dbg_bus.dbg_ack), 32'd0);
        @(negedge clock);
        chk("t3_ack", 32'(dbg_bus.dbg_ack), 32'd1);
        chk("t3_rdata", dbg_bus.dbg_rdata, shadow[40]);
        @(posedge clock); #1;
        dbg_bus.dbg_req = 1'b0;

        // Same-cycle core and debug writes to x3: core first, debug after.
        core_busy = 1'b1; core_rd_wen = 1'b1; core_rd_waddr = 6'd3; core_rd_wdata = 32'd1;
        dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b1;
        dbg_bus.dbg_addr = 6'd3; dbg_bus.dbg_wdata = 32'd2;
        @(negedge clock);
        chk("t4_core_wdata", rf_rd_wdata, 32'd1);
        chk("t4_core_wen", 32'(rf_rd_wen), 32'd1);
        @(posedge clock); #1;
        core_busy = 1'b0; core_rd_wen = 1'b0;
        @(negedge clock);
        chk("t4_dbg_wdata", rf_rd_wdata, 32'd2);
        chk("t4_dbg_waddr", 32'(rf_rd_waddr), 32'd3);
        @(negedge clock);
        chk("t4_ack", 32'(dbg_bus.dbg_ack), 32'd1);
        @(posedge clock); #1;
        dbg_bus.dbg_req = 1'b0;
        shadow[3] = 32'd2;
        dbg_op(1'b0, 6'd3, 32'h0, rd, lat, st);
        chk("t4_final", rd, 32'd2);

        // CSR read after a core write; x0 write is issued but reads back zero.
        core_wr(MSCRATCH, 32'hA5A5A5A5);
        dbg_op(1'b0, MSCRATCH, 32'h0, rd, lat, st);
        chk("t5_mscratch", rd, 32'hA5A5A5A5);
        dbg_op(1'b1, 6'd0, 32'hFFFF_FFFF, rd, lat, st);
        chk("t5_x0_wen", 32'(t0_wen), 32'd1);
        dbg_op(1'b0, 6'd0, 32'h0, rd, lat, st);
        chk("t5_x0_read", rd, 32'd0);

        // Reset during RD_RESP discards the pending ack.
        dbg_op(1'b0, 6'd7, 32'h0, rd, lat, st);
        dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_we = 1'b0; dbg_bus.dbg_addr = 6'd7;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; dbg_bus.dbg_req = 1'b0;
        @(negedge clock);
        chk("t6_ack", 32'(dbg_bus.dbg_ack), 32'd0);
        chk("t6_rdata", dbg_bus.dbg_rdata, 32'd0);
        chk("t6_stall", 32'(core_stall), 32'd0);
        @(negedge clock);
        chk("t6_ack_late", 32'(dbg_bus.dbg_ack), 32'd0);
        @(posedge clock); #1;
        dbg_op(1'b0, 6'd7, 32'h0, rd, lat, st);
        chk("t6_after_lat", 32'(lat), 32'd2);
        chk("t6_after_rdata", rd, 32'hDEADBEEF);

        // Random traffic: core writes x8..x31, debug owns x32..x63.
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    @(posedge clock); #1;
                    core_busy     = core_stall ? ($urandom % 4 == 0) : ($urandom % 3 != 0);
                    core_rd_wen   = core_busy && ($urandom % 2 == 1);
                    core_rd_waddr = 6'(8 + $urandom % 24);
                    core_rd_wdata = $urandom;
                    core_rb_raddr = 6'($urandom);
                    if (core_rd_wen) shadow[core_rd_waddr] = core_rd_wdata;
                    @(negedge clock);
                    if (core_busy) begin
                        chk("rnd_core_ctl", 32'({rf_rd_wen, rf_rd_waddr, rf_rb_raddr}),
                            32'({core_rd_wen, core_rd_waddr, core_rb_raddr}));
                        if (core_rd_wen) chk("rnd_core_wdata", rf_rd_wdata, core_rd_wdata);
                    end
                end
                core_busy = 1'b0; core_rd_wen = 1'b0;
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [5:0]  a;
                    logic [31:0] d;
                    d = $urandom;
                    if ($urandom % 2 == 1) begin
                        a = 6'(32 + $urandom % 32);
                        dbg_op(1'b1, a, d, rd, lat, st);
                        shadow[a] = d;
                    end else begin
                        a = ($urandom % 2 == 1) ? 6'(32 + $urandom % 32) : 6'(1 + $urandom % 7);
                        dbg_op(1'b0, a, 32'h0, rd, lat, st);
                        chk($sformatf("rnd_rd_x%0d", a), rd, shadow[a]);
                    end
                end
                rnd_done = 1'b1;
            end
        join
        @(posedge clock); #1;
        core_busy = 1'b0; core_rd_wen = 1'b0;

        for (int i = 8; i < 32; i++) begin
            dbg_op(1'b0, 6'(i), 32'h0, rd, lat, st);
            chk($sformatf("core_rb_x%0d", i), rd, shadow[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
